nzcv_flag_gen: RTL and testbench

- Producer side of the branch condition flags interface: computes and holds the NZCV flags that the branch condition checker consumes.
- Sits between the ALU issue stage and the branch checker.
- Runs ADD/SUB/AND/ORR through a two-stage pipeline, returns the result with a valid/ready handshake, and commits flags in program order.
- Exposes a pending indicator so branch evaluation stalls until in-flight flag writes land.

---
 rtl/nzcv_flag_gen_pkg.sv | 17 +
 rtl/nzcv_alu_comb.sv | 47 ++++
 rtl/nzcv_flag_gen.sv | 101 ++++++++++
 tb/tb_nzcv_flag_gen.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nzcv_flag_gen_pkg.sv
// NZCV flag generator shared definitions.
// Flag bit positions and ALU op encoding, also used by the branch checker.
package nzcv_flag_gen_pkg;

  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_ORR = 2'b11
  } op_t;

endpackage

// File: rtl/nzcv_alu_comb.sv
// Combinational ALU result and NZCV flag calculator.
// Ports: op, a, b, flags_in (current C/V source) -> res, flags_out {Z,C,N,V}.
module nzcv_alu_comb
  import nzcv_flag_gen_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  op_t               op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        flags_in,
  output logic [DATA_W-1:0] res,
  output logic [3:0]        flags_out
);

  logic              sub;
  logic [DATA_W-1:0] b_op;
  logic [DATA_W:0]   sum;
  logic              c;
  logic              v;

  always_comb begin
    sub  = (op == OP_SUB);
    b_op = sub ? ~b : b;
    sum  = {1'b0, a} + {1'b0, b_op}
         + {{DATA_W{1'b0}}, sub};
    res  = sum[DATA_W-1:0];
    c    = flags_in[FLAG_C];
    v    = flags_in[FLAG_V];
    unique case (op)
      OP_ADD, OP_SUB: begin
        c = sum[DATA_W];
        // Inverted b folds the SUB sign rule into the ADD one.
        v = (a[DATA_W-1] == b_op[DATA_W-1])
          && (res[DATA_W-1] != a[DATA_W-1]);
      end
      OP_AND: res = a & b;
      OP_ORR: res = a | b;
    endcase
    flags_out         = '0;
    flags_out[FLAG_Z] = (res == '0);
    flags_out[FLAG_C] = c;
    flags_out[FLAG_N] = res[DATA_W-1];
    flags_out[FLAG_V] = v;
  end

endmodule

// File: rtl/nzcv_flag_gen.sv
// Two-stage ADD/SUB/AND/ORR pipe producing in-order NZCV flags.
// Ports: in_* op handshake, res_* result handshake, flag_load direct write, flags, flags_pending.
module nzcv_flag_gen
  import nzcv_flag_gen_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        op,
  input  logic              set_flags,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res,
  input  logic              flag_load,
  output logic              flag_load_ready,
  input  logic [3:0]        flag_load_data,
  output logic [3:0]        flags,
  output logic              flags_pending
);

  logic              s1_valid;
  logic              s1_set;
  op_t               s1_op;
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;

  logic              advance;
  logic              accept;
  logic              load_acc;
  logic [DATA_W-1:0] alu_res;
  logic [3:0]        alu_flags;

  assign advance  = s1_valid
                  && (!res_valid || res_ready);
  assign in_ready = !s1_valid || advance;
  assign accept   = in_valid && in_ready;

  // Only S1 can hold an uncommitted flag write,
  // so loads never race an ALU commit.
  assign flags_pending   = s1_valid && s1_set;
  assign flag_load_ready = !flags_pending;
  assign load_acc        = flag_load
                         && flag_load_ready;

  nzcv_alu_comb #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op        (s1_op),
    .a         (s1_a),
    .b         (s1_b),
    .flags_in  (flags),
    .res       (alu_res),
    .flags_out (alu_flags)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_set   <= 1'b0;
      s1_op    <= OP_ADD;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_set   <= set_flags;
      s1_op    <= op_t'(op);
      s1_a     <= a;
      s1_b     <= b;
    end else if (advance) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res       <= '0;
    end else if (advance) begin
      res_valid <= 1'b1;
      res       <= alu_res;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags <= 4'b0000;
    end else if (advance && s1_set) begin
      flags <= alu_flags;
    end else if (load_acc) begin
      flags <= flag_load_data;
    end
  end

endmodule

// File: tb/tb_nzcv_flag_gen.sv
// Self-checking bench for nzcv_flag_gen.
// Directed scenarios plus a random stream against an arithmetic flag model.
module tb_nzcv_flag_gen;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   op = 2'd0;
  logic         set_flags = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         res_valid;
  logic         res_ready = 1'b1;
  logic [W-1:0] res;
  logic         flag_load = 1'b0;
  logic         flag_load_ready;
  logic [3:0]   flag_load_data = 4'b0;
  logic [3:0]   flags;
  logic         flags_pending;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [W-1:0] r;
    logic [3:0]   f;
  } exp_t;

  always #5 clk = ~clk;

  nzcv_flag_gen #(.DATA_W(W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .op              (op),
    .set_flags       (set_flags),
    .a               (a),
    .b               (b),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res             (res),
    .flag_load       (flag_load),
    .flag_load_ready (flag_load_ready),
    .flag_load_data  (flag_load_data),
    .flags           (flags),
    .flags_pending   (flags_pending)
  );

  // Flags from plain integer arithmetic: carry as unsigned range,
  // overflow as signed range, {Z,C,N,V}.
  function automatic logic [3:0] model(
    input  logic [1:0]   o,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [3:0]   fin,
    output logic [W-1:0] r
  );
    longint ux, uy, sx, sy, s, smax, smin;
    logic c, v;
    ux = longint'(x);
    uy = longint'(y);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    smax = (longint'(1) <<< (W - 1)) - 1;
    smin = -(longint'(1) <<< (W - 1));
    c = fin[2];
    v = fin[0];
    r = '0;
    case (o)
      2'd0: begin
        s = ux + uy;
        r = W'(s);
        c = (s >= (longint'(1) <<< W));
        s = sx + sy;
        v = (s > smax) || (s < smin);
      end
      2'd1: begin
        r = W'(ux - uy);
        c = (ux >= uy);
        s = sx - sy;
        v = (s > smax) || (s < smin);
      end
      2'd2: r = x & y;
      default: r = x | y;
    endcase
    return {r == '0, c, r[W-1], v};
  endfunction

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(5))
      0: return '0;
      1: return '1;
      2: return {1'b1, {(W-1){1'b0}}};
      3: return {1'b0, {(W-1){1'b1}}};
      4: return W'($urandom_range(7));
      default: return W'($urandom);
    endcase
  endfunction

  // Offer one op at an idle pipe, end at the negedge after its commit.
  task automatic run_op(input logic [1:0] o,
                        input logic [W-1:0] x,
                        input logic [W-1:0] y,
                        input logic sf);
    @(negedge clk);
    op = o; a = x; b = y; set_flags = sf;
    in_valid = 1'b1; res_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_flags(input logic [3:0] d);
    @(negedge clk);
    flag_load = 1'b1; flag_load_data = d;
    @(posedge clk);
    #1 flag_load = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if (flags !== 4'b0 || res !== '0 || res_valid !== 1'b0
        || flags_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: flags=%b res=%h rv=%b pend=%b need 0000/0/0/0",
               flags, res, res_valid, flags_pending);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if (in_ready !== 1'b1 || flag_load_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: in_ready=%b flr=%b need 1/1",
               in_ready, flag_load_ready);
    end
  endtask

  task automatic test_add_overflow();
    @(negedge clk);
    op = 2'd0; a = 32'h7FFF_FFFF; b = 32'd1;
    set_flags = 1'b1; in_valid = 1'b1; res_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if (flags_pending !== 1'b1 || flags !== 4'b0000) begin
      n_fail++;
      $display("FAIL add_pending: pend=%b flags=%b need 1/0000",
               flags_pending, flags);
    end
    @(negedge clk);
    n_chk++;
    if (res !== 32'h8000_0000 || flags !== 4'b0011
        || res_valid !== 1'b1 || flags_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL add_ovf: res=%h flags=%b rv=%b pend=%b need 80000000/0011/1/0",
               res, flags, res_valid, flags_pending);
    end
  endtask

  task automatic test_sub();
    run_op(2'd1, 32'd5, 32'd5, 1'b1);
    n_chk++;
    if (res !== '0 || flags !== 4'b1100) begin
      n_fail++;
      $display("FAIL sub_eq: res=%h flags=%b need 0/1100", res, flags);
    end
    run_op(2'd1, 32'd3, 32'd5, 1'b1);
    n_chk++;
    if (res !== 32'hFFFF_FFFE || flags !== 4'b0010) begin
      n_fail++;
      $display("FAIL sub_borrow: res=%h flags=%b need fffffffe/0010",
               res, flags);
    end
  endtask

  // Pair of set_flags ops in adjacent cycles; second is a logic op
  // that must see C/V from the first.
  task automatic pair(input logic [W-1:0] x0, input logic [W-1:0] y0,
                      input logic [1:0] o1, input logic [W-1:0] x1,
                      input logic [W-1:0] y1, input logic [3:0] f0,
                      input string nm);
    logic [W-1:0] r0, r1;
    logic [3:0] e0, e1;
    e0 = model(2'd0, x0, y0, f0, r0);
    e1 = model(o1, x1, y1, e0, r1);
    @(negedge clk);
    op = 2'd0; a = x0; b = y0; set_flags = 1'b1;
    in_valid = 1'b1; res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op = o1; a = x1; b = y1;
    #1;
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_b2b_ready: in_ready=%b need 1", nm, in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if (res !== r0 || flags !== e0 || flags_pending !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_first: res=%h flags=%b pend=%b need %h/%b/1",
               nm, res, flags, flags_pending, r0, e0);
    end
    @(negedge clk);
    n_chk++;
    if (res !== r1 || flags !== e1 || flags_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_second: res=%h flags=%b pend=%b need %h/%b/0",
               nm, res, flags, flags_pending, r1, e1);
    end
  endtask

  task automatic test_back_to_back();
    pair(32'hFFFF_FFFF, 32'd1, 2'd2, 32'hF0, 32'h0F,
         flags, "and");
    n_chk++;
    if (flags !== 4'b1100) begin
      n_fail++;
      $display("FAIL and_retain: flags=%b need 1100", flags);
    end
    pair(32'h7FFF_FFFF, 32'd1, 2'd3, 32'd0, 32'd0,
         flags, "orr");
    n_chk++;
    if (flags !== 4'b1001) begin
      n_fail++;
      $display("FAIL orr_retain: flags=%b need 1001", flags);
    end
  endtask

  task automatic test_no_set();
    load_flags(4'b0100);
    @(negedge clk);
    n_chk++;
    if (flags !== 4'b0100) begin
      n_fail++;
      $display("FAIL idle_load: flags=%b need 0100", flags);
    end
    run_op(2'd0, 32'd2, 32'd3, 1'b0);
    n_chk++;
    if (res !== 32'd5 || flags !== 4'b0100) begin
      n_fail++;
      $display("FAIL no_set: res=%h flags=%b need 5/0100", res, flags);
    end
  endtask

  task automatic test_flag_load();
    logic [W-1:0] r;
    logic [3:0] e;
    e = model(2'd1, 32'd1, 32'd2, flags, r);
    @(negedge clk);
    op = 2'd1; a = 32'd1; b = 32'd2; set_flags = 1'b1;
    in_valid = 1'b1; res_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    flag_load = 1'b1; flag_load_data = 4'b1010;
    #1;
    n_chk++;
    if (flag_load_ready !== 1'b0 || flags_pending !== 1'b1) begin
      n_fail++;
      $display("FAIL load_blocked: flr=%b pend=%b need 0/1",
               flag_load_ready, flags_pending);
    end
    @(negedge clk);
    n_chk++;
    if (flags !== e || flag_load_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL load_commit_first: flags=%b flr=%b need %b/1",
               flags, flag_load_ready, e);
    end
    @(posedge clk);
    #1 flag_load = 1'b0;
    @(negedge clk);
    n_chk++;
    if (flags !== 4'b1010) begin
      n_fail++;
      $display("FAIL load_applied: flags=%b need 1010", flags);
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] got[$];
    logic [W-1:0] exp_q[$];
    logic acc;
    exp_q = '{32'd3, 32'd7, 32'hA5};
    @(negedge clk);
    res_ready = 1'b0; set_flags = 1'b0;
    op = 2'd0; a = 32'd1; b = 32'd2; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op = 2'd1; a = 32'd10; b = 32'd3;
    #1;
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_second_ready: in_ready=%b need 1", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    op = 2'd3; a = 32'h05; b = 32'hA0;
    repeat (3) begin
      #1;
      n_chk++;
      if (in_ready !== 1'b0 || res_valid !== 1'b1 || res !== 32'd3) begin
        n_fail++;
        $display("FAIL stall_hold: in_ready=%b rv=%b res=%h need 0/1/3",
                 in_ready, res_valid, res);
      end
      @(negedge clk);
    end
    res_ready = 1'b1;
    for (int i = 0; i < 12 && got.size() < 3; i++) begin
      #1;
      acc = in_valid && in_ready;
      if (res_valid && res_ready) got.push_back(res);
      @(negedge clk);
      if (acc) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if (got.size() != 3 || res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_count: got=%0d rv=%b need 3/0",
               got.size(), res_valid);
    end
    for (int i = 0; i < got.size() && i < 3; i++) begin
      n_chk++;
      if (got[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL stall_order[%0d]: res=%h need %h", i, got[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t e;
    logic [3:0] mf;
    logic acc;
    bit done;
    mf = 4'($urandom);
    load_flags(mf);
    done = 1'b0;
    for (int cyc = 0; cyc < 1000 && !done; cyc++) begin
      @(negedge clk);
      if (!in_valid && cyc < 400 && $urandom_range(3) != 0) begin
        op = 2'($urandom); a = rnd_val(); b = rnd_val();
        set_flags = 1'($urandom);
        in_valid = 1'b1;
      end
      res_ready = (cyc >= 400) || ($urandom_range(3) != 0);
      #1;
      if (res_valid && res_ready) begin
        n_chk++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL rand_extra: res=%h with nothing outstanding", res);
        end else begin
          e = q.pop_front();
          if (res !== e.r || flags !== e.f) begin
            n_fail++;
            $display("FAIL rand_op: res=%h flags=%b need %h/%b",
                     res, flags, e.r, e.f);
          end
        end
      end
      acc = in_valid && in_ready;
      if (acc) begin
        if (set_flags) mf = model(op, a, b, mf, e.r);
        else void'(model(op, a, b, mf, e.r));
        e.f = mf;
        q.push_back(e);
      end
      @(posedge clk);
      #1 if (acc) in_valid = 1'b0;
      done = (cyc >= 400) && (q.size() == 0) && !in_valid;
    end
    n_chk++;
    if (!done) begin
      n_fail++;
      $display("FAIL rand_drain: %0d results outstanding, need 0", q.size());
    end
  endtask

  task automatic test_async_reset();
    load_flags(4'b1111);
    @(negedge clk);
    res_ready = 1'b0; set_flags = 1'b0;
    op = 2'd0; a = 32'd4; b = 32'd4; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    set_flags = 1'b1; op = 2'd1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if (res_valid !== 1'b1 || flags_pending !== 1'b1 || flags !== 4'b1111) begin
      n_fail++;
      $display("FAIL arst_pre: rv=%b pend=%b flags=%b need 1/1/1111",
               res_valid, flags_pending, flags);
    end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (flags !== 4'b0 || res !== '0 || res_valid !== 1'b0
        || flags_pending !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_now: flags=%b res=%h rv=%b pend=%b ir=%b need 0000/0/0/0/1",
               flags, res, res_valid, flags_pending, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1; res_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if (flags !== 4'b0 || res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_after: flags=%b rv=%b need 0000/0", flags, res_valid);
    end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_sub();
    test_back_to_back();
    test_no_set();
    test_flag_load();
    test_stall();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
